// File: rtl/apb_wait_slave.sv
// APB completer with a byte-wide register file, programmable wait states,
// out-of-range error response and a sticky protocol-violation flag.
module apb_wait_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_write;
  logic [7:0] r_mem [DEPTH];

  logic       w_setup;
  logic       w_violate;
  logic       w_wr_en;
  logic       w_rdy_nxt;
  logic [7:0] w_src_addr;
  logic       w_src_write;
  logic       w_src_ok;

  // zero-wait completion responds from the live setup-phase bus
  assign w_src_addr  = (r_state == S_IDLE) ? paddr : r_addr;
  assign w_src_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_src_ok    = {1'b0, w_src_addr} < 9'(DEPTH);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdy_nxt   = 1'b0;
    w_setup     = 1'b0;
    w_violate   = 1'b0;
    w_wr_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_setup     = 1'b1;
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = WAIT_INIT;
          w_rdy_nxt   = (WAIT_INIT == 4'd0);
        end else if (psel && penable) begin
          w_violate = 1'b1;
        end
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nxt = S_IDLE;
          w_wr_en     = r_write && w_src_ok;
        end else if (!psel) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (penable) begin
          if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
          w_rdy_nxt = (r_cnt <= 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      pready  <= w_rdy_nxt;
      prdata  <= '0;
      pslverr <= 1'b0;
      if (w_rdy_nxt) begin
        pslverr <= !w_src_ok;
        if (w_src_ok && !w_src_write)
          prdata <= r_mem[w_src_addr[AW-1:0]];
      end
      if (w_setup) begin
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_write <= pwrite;
      end
      if (w_violate) proto_err <= 1'b1;
      if (w_wr_en) r_mem[r_addr[AW-1:0]] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: one instance with two wait states,
// one zero-wait instance, hand-computed expected responses.
module tb_apb_wait_slave;

  logic       pclk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       dsel;

  logic       psel_a, psel_b;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b;
  logic       pslverr_a, pslverr_b;
  logic       perr_a, perr_b;

  logic [7:0] m_rdata;
  logic       m_ready;
  logic       m_slverr;
  logic       m_proto;

  int total = 0;
  int bad   = 0;

  logic [7:0] rd;
  logic       er;
  int         lat;

  assign psel_a   = psel & ~dsel;
  assign psel_b   = psel & dsel;
  assign m_rdata  = dsel ? prdata_b  : prdata_a;
  assign m_ready  = dsel ? pready_b  : pready_a;
  assign m_slverr = dsel ? pslverr_b : pslverr_a;
  assign m_proto  = dsel ? perr_b    : perr_a;

  apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
    .proto_err(perr_a)
  );

  apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
    .proto_err(perr_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // bus signals change #1 after a rising edge; outputs sampled on falling edge
  task automatic xfer(input logic wr, input logic [7:0] a,
                      input logic [7:0] d, output logic [7:0] r,
                      output logic e, output int l);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = ~a; pwdata = ~d; pwrite = ~wr;
    l = 0; r = 8'h00; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge pclk);
      if (m_ready) begin
        l = i; r = m_rdata; e = m_slverr;
        break;
      end
      @(posedge pclk); #1;
    end
    if (l == 0) check("xfer_timeout", 32'd0, 32'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a,
                        input logic [7:0] d, input logic exp_err,
                        input int exp_lat);
    xfer(1'b1, a, d, rd, er, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [7:0] exp_d, input logic exp_err,
                        input int exp_lat);
    xfer(1'b0, a, 8'h00, rd, er, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {24'd0, rd}, {24'd0, exp_d});
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; dsel = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", {31'd0, pready_a}, 32'd0);
    check("rst_prdata", {24'd0, prdata_a}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
    check("rst_proto", {31'd0, perr_a}, 32'd0);
    preset = 1'b0;
    idle(2);

    wr_chk("w03", 8'h03, 8'hA5, 1'b0, 3);
    @(negedge pclk);
    check("pready_drop", {31'd0, pready_a}, 32'd0);
    idle(1);
    rd_chk("r03", 8'h03, 8'hA5, 1'b0, 3);
    idle(1);

    wr_chk("w40", 8'h40, 8'h5A, 1'b1, 3);
    idle(1);
    rd_chk("r40", 8'h40, 8'h00, 1'b1, 3);
    idle(1);
    rd_chk("r3f", 8'h3F, 8'h00, 1'b0, 3);
    rd_chk("r03b", 8'h03, 8'hA5, 1'b0, 3);
    idle(1);

    wr_chk("b2b_w00", 8'h00, 8'h11, 1'b0, 3);
    wr_chk("b2b_w01", 8'h01, 8'h22, 1'b0, 3);
    rd_chk("b2b_r00", 8'h00, 8'h11, 1'b0, 3);
    rd_chk("b2b_r01", 8'h01, 8'h22, 1'b0, 3);
    idle(1);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h05; pwdata = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort_acc1", {31'd0, pready_a}, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("abort_nordy", {31'd0, pready_a}, 32'd0);
    end
    idle(1);
    rd_chk("abort_r05", 8'h05, 8'h00, 1'b0, 3);
    idle(1);

    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 8'h02; pwdata = 8'h77;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("proto_set", {31'd0, perr_a}, 32'd1);
    check("proto_nordy", {31'd0, pready_a}, 32'd0);
    idle(2);
    check("proto_sticky", {31'd0, perr_a}, 32'd1);
    rd_chk("proto_r02", 8'h02, 8'h00, 1'b0, 3);
    idle(1);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h07; pwdata = 8'h3C;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    #1;
    check("mrst_pready", {31'd0, pready_a}, 32'd0);
    check("mrst_prdata", {24'd0, prdata_a}, 32'd0);
    check("mrst_pslverr", {31'd0, pslverr_a}, 32'd0);
    check("mrst_proto", {31'd0, perr_a}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    idle(2);
    preset = 1'b0;
    idle(1);
    rd_chk("mrst_r07", 8'h07, 8'h00, 1'b0, 3);
    check("mrst_proto_after", {31'd0, perr_a}, 32'd0);
    idle(1);

    dsel = 1'b1;
    idle(1);
    wr_chk("z_w00", 8'h00, 8'h11, 1'b0, 1);
    wr_chk("z_w01", 8'h01, 8'h22, 1'b0, 1);
    rd_chk("z_r00", 8'h00, 8'h11, 1'b0, 1);
    rd_chk("z_r01", 8'h01, 8'h22, 1'b0, 1);
    rd_chk("z_r40", 8'h40, 8'h00, 1'b1, 1);
    check("z_proto", {31'd0, m_proto}, 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
